// File: rtl/seg_msg_pkg.sv
// Shared constants, state encoding and the ASCII-to-digit-code map for the
// 7-segment message controller.
package seg_msg_pkg;

    localparam logic [5:0] CH_BLANK = 6'h3F;
    localparam logic [5:0] CH_A     = 6'd10;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_STATIC = 2'd1,
        S_SCROLL = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    // Returns {valid, code}; valid=0 means the byte is not a displayable character.
    function automatic logic [6:0] ascii_to_code(input logic [7:0] c);
        logic [6:0] r;
        r = 7'd0;
        if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 6'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h5A) r = {1'b1, 6'(c - 8'h41) + CH_A};
        else if (c >= 8'h61 && c <= 8'h7A) r = {1'b1, 6'(c - 8'h61) + CH_A};
        else if (c == 8'h20)               r = {1'b1, CH_BLANK};
        return r;
    endfunction

endpackage

// File: rtl/seg_msg_ctrl_if.sv
// Byte-stream interface into the message controller; SEG_MSG_ECHO_EN adds the
// echo (tx) channel.
interface seg_msg_ctrl_if;
    // Valid/ready: a byte moves on a rising clock edge where valid && ready;
    // the source holds data stable and valid high until that edge, and ready
    // never depends on valid.
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
`ifdef SEG_MSG_ECHO_EN
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
`endif

    modport master (
        output rx_data, rx_valid,
        input  rx_ready
`ifdef SEG_MSG_ECHO_EN
        , input tx_data, tx_valid
        , output tx_ready
`endif
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready
`ifdef SEG_MSG_ECHO_EN
        , output tx_data, tx_valid
        , input  tx_ready
`endif
    );

endinterface

// File: rtl/seg_msg_scroll_tick.sv
// Scroll-step prescaler: counts 0..SCROLL_TICKS-1 while enabled and emits a
// one-cycle step pulse on the wrap; clear forces the count to zero.
module seg_msg_scroll_tick #(
    parameter int SCROLL_TICKS = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic step_o
);
    localparam int CW = $clog2(SCROLL_TICKS);
    localparam logic [CW-1:0] LAST = CW'(SCROLL_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    assign step_o = en_i && !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_msg_ctrl.sv
// Message controller for the 8-digit 7-segment driver: buffers an ASCII
// message, commits it on CR, shows it static or scrolling. Option: SEG_MSG_ECHO_EN.
module seg_msg_ctrl
    import seg_msg_pkg::*;
#(
    parameter int MSG_MAX      = 16,
    parameter int SCROLL_TICKS = 25_000_000,
    parameter int SCROLL_GAP   = 2
) (
    input  logic          sys_clk,
    input  logic          rst,
    seg_msg_ctrl_if.slave rx,
    output logic [2:0]    ndigits,
    output logic [5:0]    dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
    output logic [4:0]    msg_len,
    output logic          scrolling,
    output logic          overflow,
    output state_t        dbg_state
);
    localparam logic [4:0] MAX5 = 5'(MSG_MAX);
    localparam logic [5:0] GAP6 = 6'(SCROLL_GAP);

    state_t     state_q, state_d;
    logic [4:0] count_q, count_d, len_q, len_d;
    logic [5:0] ptr_q, ptr_d, period_q, p_d, e;
    logic       ovf_q, ovf_d, scroll_q, scroll_d, rdy_q;
    logic [2:0] ndig_q, ndig_d;
    logic [5:0] dig_q [8];
    logic [5:0] dig_d [8];
    logic [5:0] shadow_q [32];
    logic [5:0] shadow_d [32];
    logic [5:0] act_q [32];
    logic [5:0] act_d [32];
    logic [6:0] code;
    logic       accept, is_cr, is_bs, step, tick_clr;

    assign code     = ascii_to_code(rx.rx_data);
    assign is_cr    = (rx.rx_data == ASCII_CR);
    assign is_bs    = (rx.rx_data == ASCII_BS);
    assign period_q = {1'b0, len_q} + GAP6;
    assign accept   = rx.rx_valid && rx.rx_ready;

`ifdef SEG_MSG_ECHO_EN
    logic [7:0] tx_data_q;
    logic       tx_valid_q;

    // An unsent echo byte stalls the receive side.
    assign rx.rx_ready = rdy_q && !(tx_valid_q && !rx.tx_ready);
    assign rx.tx_data  = tx_data_q;
    assign rx.tx_valid = tx_valid_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (accept) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= rx.rx_data;
        end else if (tx_valid_q && rx.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end
`else
    assign rx.rx_ready = rdy_q;
`endif

    // A CR in the same cycle as a wrap clears the prescaler, so the step is lost.
    assign tick_clr = (state_q != S_SCROLL) || (accept && is_cr);

    seg_msg_scroll_tick #(.SCROLL_TICKS(SCROLL_TICKS)) u_tick (
        .clk_i  (sys_clk),
        .rst_i  (rst),
        .clr_i  (tick_clr),
        .en_i   (state_q == S_SCROLL),
        .step_o (step)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        len_d    = len_q;
        ptr_d    = ptr_q;
        ovf_d    = ovf_q;
        ndig_d   = ndig_q;
        dig_d    = dig_q;
        scroll_d = scroll_q;
        p_d      = '0;
        e        = '0;
        if (state_q == S_COMMIT) begin
            act_d   = shadow_q;
            len_d   = count_q;
            count_d = '0;
            ovf_d   = 1'b0;
            ptr_d   = '0;
            if (count_q == 5'd0)      state_d = S_BLANK;
            else if (count_q <= 5'd8) state_d = S_STATIC;
            else                      state_d = S_SCROLL;
        end else begin
            if (step) ptr_d = (ptr_q == period_q - 6'd1) ? '0 : ptr_q + 6'd1;
            if (accept) begin
                if (is_cr) begin
                    state_d = S_COMMIT;
                end else if (is_bs) begin
                    if (count_q != 5'd0) count_d = count_q - 5'd1;
                end else if (code[6]) begin
                    if (count_q == MAX5) begin
                        ovf_d = 1'b1;
                    end else begin
                        shadow_d[count_q] = code[5:0];
                        count_d           = count_q + 5'd1;
                    end
                end
            end
        end
        // Display registers follow the next state; they hold through the commit cycle.
        if (state_d != S_COMMIT) begin
            p_d      = {1'b0, len_d} + GAP6;
            scroll_d = (state_d == S_SCROLL);
            for (int i = 0; i < 8; i++) dig_d[3'(i)] = CH_BLANK;
            case (state_d)
                S_STATIC: begin
                    ndig_d = len_d[2:0];
                    for (int i = 0; i < 8; i++)
                        if (5'(i) < len_d) dig_d[3'(i)] = act_d[len_d - 5'd1 - 5'(i)];
                end
                S_SCROLL: begin
                    ndig_d = 3'd0;
                    for (int j = 0; j < 8; j++) begin
                        e = ptr_d + 6'(j);
                        if (e >= p_d) e = e - p_d;
                        if (e < {1'b0, len_d}) dig_d[3'(7 - j)] = act_d[e[4:0]];
                    end
                end
                default: ndig_d = 3'd1;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= S_BLANK;
            count_q  <= '0;
            len_q    <= '0;
            ptr_q    <= '0;
            ovf_q    <= 1'b0;
            ndig_q   <= 3'd1;
            scroll_q <= 1'b0;
            rdy_q    <= 1'b1;
            for (int i = 0; i < 8; i++) dig_q[i] <= CH_BLANK;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
            ndig_q   <= ndig_d;
            scroll_q <= scroll_d;
            rdy_q    <= (state_d != S_COMMIT);
            dig_q    <= dig_d;
        end
    end

    // Message storage needs no reset: count/length gate every read.
    always_ff @(posedge sys_clk) begin
        shadow_q <= shadow_d;
        act_q    <= act_d;
    end

    assign ndigits   = ndig_q;
    assign msg_len   = len_q;
    assign scrolling = scroll_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;
    assign dig0 = dig_q[0];
    assign dig1 = dig_q[1];
    assign dig2 = dig_q[2];
    assign dig3 = dig_q[3];
    assign dig4 = dig_q[4];
    assign dig5 = dig_q[5];
    assign dig6 = dig_q[6];
    assign dig7 = dig_q[7];

endmodule

// File: tb/tb_seg_msg_ctrl.sv
// Bench for seg_msg_ctrl: directed and random messages checked against a
// queue-based model of the message/display rules.
module tb_seg_msg_ctrl;
    import seg_msg_pkg::*;

    localparam int TICKS = 4;
    localparam int GAP   = 2;
    localparam int MAXC  = 16;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_msg_ctrl_if bus();
    logic [2:0] ndigits;
    logic [5:0] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
    logic [4:0] msg_len;
    logic       scrolling, overflow;
    state_t     dbg_state;
    logic [5:0] dut_dig [8];

    assign dut_dig[0] = dig0;
    assign dut_dig[1] = dig1;
    assign dut_dig[2] = dig2;
    assign dut_dig[3] = dig3;
    assign dut_dig[4] = dig4;
    assign dut_dig[5] = dig5;
    assign dut_dig[6] = dig6;
    assign dut_dig[7] = dig7;

    seg_msg_ctrl #(.MSG_MAX(MAXC), .SCROLL_TICKS(TICKS), .SCROLL_GAP(GAP)) dut (
        .sys_clk(clk), .rst(rst), .rx(bus),
        .ndigits(ndigits),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .dig4(dig4), .dig5(dig5), .dig6(dig6), .dig7(dig7),
        .msg_len(msg_len), .scrolling(scrolling), .overflow(overflow),
        .dbg_state(dbg_state)
    );

`ifdef SEG_MSG_ECHO_EN
    initial bus.tx_ready = 1'b1;
`endif

    // scoreboard state
    int checks = 0;
    int errors = 0;
    int sh[$];
    int act[$];
    bit m_ovf = 1'b0;
    logic [47:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int map_code(input int b);
        if (b >= 48 && b <= 57)  return b - 48;
        if (b >= 65 && b <= 90)  return b - 55;
        if (b >= 97 && b <= 122) return b - 87;
        if (b == 32)             return 63;
        return -1;
    endfunction

    task automatic model_apply(input int b);
        if (b == 13) begin
            act = sh;
            sh.delete();
            m_ovf = 1'b0;
        end else if (b == 8) begin
            if (sh.size() > 0) void'(sh.pop_back());
        end else if (map_code(b) >= 0) begin
            if (sh.size() == MAXC) m_ovf = 1'b1;
            else sh.push_back(map_code(b));
        end
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rx_ready_wait", 32'(t < 20), 1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        model_apply(int'(b));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic commit();
        send_byte(CR);
        chk("rdy_low_commit", 32'(bus.rx_ready), 0);
        chk("state_commit", 32'(dbg_state), 32'(S_COMMIT));
        @(posedge clk);
        #1;
        chk("rdy_high_after", 32'(bus.rx_ready), 1);
    endtask

    // k = cycles elapsed since the committed message became visible
    task automatic check_display(input int k, input string tag);
        logic [5:0]  e_dig [8];
        logic [47:0] pk, ex;
        int L, nd, ptr, e;
        L = act.size();
        nd = 1;
        for (int i = 0; i < 8; i++) e_dig[i] = 6'd63;
        if (L >= 1 && L <= 8) begin
            nd = L % 8;
            for (int i = 0; i < L; i++) e_dig[i] = 6'(act[L - 1 - i]);
        end else if (L > 8) begin
            nd = 0;
            ptr = (k / TICKS) % (L + GAP);
            for (int j = 0; j < 8; j++) begin
                e = (ptr + j) % (L + GAP);
                if (e < L) e_dig[7 - j] = 6'(act[e]);
            end
        end
        for (int i = 0; i < 8; i++) pk[i*6 +: 6] = e_dig[i];
        exp_q.push_back(pk);
        ex = exp_q.pop_front();
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_k%0d_dig%0d", tag, k, i), 32'(dut_dig[i]), 32'(ex[i*6 +: 6]));
        chk($sformatf("%s_k%0d_ndigits", tag, k), 32'(ndigits), nd);
        chk($sformatf("%s_k%0d_msg_len", tag, k), 32'(msg_len), L);
        chk($sformatf("%s_k%0d_scrolling", tag, k), 32'(scrolling), 32'(L > 8));
        chk($sformatf("%s_k%0d_overflow", tag, k), 32'(overflow), 32'(m_ovf));
    endtask

    task automatic walk(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            check_display(k, tag);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 7))
            0: return 8'(48 + $urandom_range(0, 9));
            1: return 8'(97 + $urandom_range(0, 25));
            2: return 8'h20;
            3: return BS;
            4: return 8'(8'h21 + $urandom_range(0, 14));
            default: return 8'(65 + $urandom_range(0, 25));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_display(0, "reset");
        chk("reset_rx_ready", 32'(bus.rx_ready), 1);

        send_str("HELLO");
        commit();
        check_display(0, "hello");

        send_str("12345678");
        commit();
        check_display(0, "eight");

        send_str("ABCDEFGHIJ");
        commit();
        walk(54, "scroll");

        repeat (20) send_byte("A");
        chk("ovf_before_cr", 32'(overflow), 1);
        commit();
        check_display(0, "ovf_commit");

        repeat (17) send_byte("B");
        send_byte(BS);
        chk("ovf_after_bs", 32'(overflow), 1);
        commit();
        check_display(0, "bs_at_max");

        send_str("AB");
        send_byte(BS);
        send_str("C");
        commit();
        check_display(0, "ab_bs_c");

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) send_byte(rand_byte());
            commit();
            walk(22, $sformatf("rand%0d", r));
        end

        // reset landing on a scroll step edge, with bytes pending in the shadow
        send_str("ABCDEFGHIJK");
        commit();
        send_str("XY");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sh.delete();
        act.delete();
        m_ovf = 1'b0;
        check_display(0, "rst_mid");
        chk("rst_mid_rx_ready", 32'(bus.rx_ready), 1);
        chk("rst_mid_state", 32'(dbg_state), 32'(S_BLANK));
        commit();
        check_display(0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
